// File: rtl/sine_rom_sequencer_pkg.sv
// Shared definitions for the sine ROM sequencer: FSM state encoding and
// the default phase accumulator width.
package sine_rom_sequencer_pkg;

    localparam int SINE_PHASE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

endpackage

// File: rtl/sine_rom_sequencer_if.sv
// Valid/ready sample stream leaving the sequencer.
interface sine_rom_sequencer_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sine_rom_sequencer_sample_fifo2.sv
// Two-entry output buffer; head entry drives the sample stream.
module sample_fifo2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [1:0]       occ_o
);
    logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]       occ_q, occ_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        unique case ({push_i, pop_i})
            2'b10: begin
                if (occ_q == 2'd0) head_d = push_data_i;
                else               tail_d = push_data_i;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // occupancy unchanged; with one entry the new word becomes the head
                if (occ_q == 2'd1) begin
                    head_d = push_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign data_o  = head_q;
    assign valid_o = (occ_q != 2'd0);
    assign occ_o   = occ_q;
endmodule

// File: rtl/sine_rom_sequencer.sv
// Phase-accumulator ROM sequencer streaming samples through a 2-entry buffer.
//   state    | meaning
//   ST_IDLE  | waiting for start, no reads issued
//   ST_RUN   | issuing ROM reads whenever the buffer has room
//   ST_DRAIN | no new reads; delivering in-flight and buffered samples
module sine_rom_sequencer
    import sine_rom_sequencer_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int DEPTH   = 64,
    parameter  int PHASE_W = SINE_PHASE_W,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic [PHASE_W-1:0]   step_i,
    output logic                 rom_en_o,
    output logic [AW-1:0]        rom_addr_o,
    input  logic [WIDTH-1:0]     rom_data_i,
    output logic                 busy_o,
    output logic                 wrap_o,
    sine_rom_sequencer_if.master smp
);
    seq_state_e         state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d, step_q, step_d;
    logic               pend_q;
    logic [PHASE_W:0]   phase_sum;
    logic [1:0]         occ;
    logic [WIDTH-1:0]   head_data;
    logic               head_valid, pop, room, launch, drained, issue;

    assign pop       = head_valid & smp.ready;
    // a new read lands in the buffer next cycle, so count the one already in flight
    assign room      = ({1'b0, occ} + {2'b00, pend_q}) < (3'd2 + {2'b00, pop});
    assign launch    = start_i & ~stop_i;
    assign drained   = ~pend_q & (occ == 2'd0);
    assign phase_sum = {1'b0, phase_q} + {1'b0, step_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (launch)  state_d = ST_RUN;
            ST_RUN:   if (stop_i)  state_d = ST_DRAIN;
            ST_DRAIN: if (drained) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o   = (state_q != ST_IDLE);
        issue    = (state_q == ST_RUN) & ~stop_i & room;
        rom_en_o = issue;
        wrap_o   = issue & phase_sum[PHASE_W];
    end

    always_comb begin
        phase_d = phase_q;
        step_d  = step_q;
        if ((state_q == ST_IDLE) && launch) begin
            phase_d = '0;
            step_d  = step_i;
        end else if (issue) begin
            phase_d = phase_sum[PHASE_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            step_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            step_q  <= step_d;
            pend_q  <= issue;
        end
    end

    assign rom_addr_o = phase_q[PHASE_W-1 -: AW];

    sample_fifo2 #(.WIDTH(WIDTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (pend_q),
        .push_data_i (rom_data_i),
        .pop_i       (pop),
        .data_o      (head_data),
        .valid_o     (head_valid),
        .occ_o       (occ)
    );

    assign smp.data  = head_data;
    assign smp.valid = head_valid;
endmodule

// File: tb/tb_sine_rom_sequencer.sv
// Directed bench for sine_rom_sequencer with a behavioural one-cycle ROM.
module tb_sine_rom_sequencer;
    localparam int WIDTH   = 32;
    localparam int DEPTH   = 64;
    localparam int PHASE_W = 16;
    localparam int AW      = 6;

    logic               clk   = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               stop  = 1'b0;
    logic [PHASE_W-1:0] step  = '0;
    logic               rom_en;
    logic [AW-1:0]      rom_addr;
    logic [WIDTH-1:0]   rom_data;
    logic               busy;
    logic               wrap;

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW-1:0]    addr_q[$];
    logic             wrap_q[$];
    logic [WIDTH-1:0] smp_q[$];

    sine_rom_sequencer_if #(.WIDTH(WIDTH)) smp_if ();

    sine_rom_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PHASE_W(PHASE_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .stop_i     (stop),
        .step_i     (step),
        .rom_en_o   (rom_en),
        .rom_addr_o (rom_addr),
        .rom_data_i (rom_data),
        .busy_o     (busy),
        .wrap_o     (wrap),
        .smp        (smp_if)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input int a);
        logic [7:0] b;
        b = 8'(a);
        return {b, 8'hC3, ~b, b ^ 8'h5A};
    endfunction

    always @(posedge clk) if (rom_en === 1'b1) rom_data <= rom_word(int'(rom_addr));

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rom_en === 1'b1) begin
                addr_q.push_back(rom_addr);
                wrap_q.push_back(wrap);
            end
            if (smp_if.valid === 1'b1 && smp_if.ready === 1'b1) smp_q.push_back(smp_if.data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [PHASE_W-1:0] s);
        addr_q.delete();
        wrap_q.delete();
        smp_q.delete();
        tick();
        start = 1'b1;
        step  = s;
        tick();
        start = 1'b0;
        step  = 16'hBEEF;
    endtask

    task automatic wait_issues(input int n);
        int c = 0;
        while (addr_q.size() < n && c < 2000) begin
            tick();
            c++;
        end
        chk("issue_timeout", 32'(c < 2000), 32'd1);
    endtask

    task automatic stop_and_drain(input string tag);
        int c = 0;
        tick();
        stop = 1'b1;
        @(negedge clk);
        chk({tag, "_stop_rom_en"}, 32'(rom_en), 32'd0);
        chk({tag, "_stop_busy"}, 32'(busy), 32'd1);
        tick();
        stop = 1'b0;
        @(negedge clk);
        chk({tag, "_drain_busy"}, 32'(busy), 32'd1);
        chk({tag, "_drain_rom_en"}, 32'(rom_en), 32'd0);
        while (busy !== 1'b0 && c < 50) begin
            tick();
            c++;
        end
        chk({tag, "_drain_timeout"}, 32'(c < 50), 32'd1);
        chk({tag, "_sample_count"}, 32'(smp_q.size()), 32'(addr_q.size()));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        smp_if.ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rom_en", 32'(rom_en), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_valid", 32'(smp_if.valid), 32'd0);
        chk("rst_data", smp_if.data, 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        rst_n = 1'b1;
        tick();

        // step 0x0400: one address per issue, wrap on the 64th read
        do_start(16'h0400);
        @(negedge clk);
        chk("a_first_busy", 32'(busy), 32'd1);
        chk("a_first_rom_en", 32'(rom_en), 32'd1);
        chk("a_first_addr", 32'(rom_addr), 32'd0);
        chk("a_lat0_valid", 32'(smp_if.valid), 32'd0);
        tick();
        @(negedge clk);
        chk("a_lat1_valid", 32'(smp_if.valid), 32'd0);
        tick();
        @(negedge clk);
        chk("a_lat2_valid", 32'(smp_if.valid), 32'd1);
        chk("a_lat2_data", smp_if.data, rom_word(0));
        wait_issues(65);
        stop_and_drain("a");
        for (int i = 0; i < 65; i++) begin
            chk("a_addr", 32'(addr_q[i]), 32'(i % 64));
            chk("a_wrap", 32'(wrap_q[i]), 32'(i == 63));
        end
        for (int i = 0; i < smp_q.size(); i++) chk("a_sample", smp_q[i], rom_word(i % 64));
        chk("a_idle_busy", 32'(busy), 32'd0);

        // step 0x0200: each address twice, wrap every 128 issues
        do_start(16'h0200);
        wait_issues(130);
        stop_and_drain("b");
        for (int i = 0; i < 130; i++) begin
            chk("b_addr", 32'(addr_q[i]), 32'((i / 2) % 64));
            chk("b_wrap", 32'(wrap_q[i]), 32'(i == 127));
        end
        for (int i = 0; i < smp_q.size(); i++) chk("b_sample", smp_q[i], rom_word((i / 2) % 64));

        // backpressure for 10 cycles mid-run
        do_start(16'h0400);
        wait_issues(10);
        tick();
        smp_if.ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("c_stall_rom_en", 32'(rom_en), 32'd0);
            chk("c_stall_valid", 32'(smp_if.valid), 32'd1);
            chk("c_stall_data", smp_if.data, rom_word(smp_q.size() % 64));
            tick();
        end
        smp_if.ready = 1'b1;
        wait_issues(40);
        stop_and_drain("c");
        for (int i = 0; i < addr_q.size(); i++) chk("c_addr", 32'(addr_q[i]), 32'(i % 64));
        for (int i = 0; i < smp_q.size(); i++) chk("c_sample", smp_q[i], rom_word(i % 64));

        // start together with stop in IDLE is ignored
        tick();
        start = 1'b1;
        stop  = 1'b1;
        step  = 16'h0400;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        chk("d_both_busy", 32'(busy), 32'd0);
        chk("d_both_rom_en", 32'(rom_en), 32'd0);
        tick();
        @(negedge clk);
        chk("d_both_busy2", 32'(busy), 32'd0);

        // step 0: address 0 forever, no wrap
        do_start(16'h0000);
        wait_issues(8);
        stop_and_drain("z");
        for (int i = 0; i < 8; i++) begin
            chk("z_addr", 32'(addr_q[i]), 32'd0);
            chk("z_wrap", 32'(wrap_q[i]), 32'd0);
        end
        for (int i = 0; i < smp_q.size(); i++) chk("z_sample", smp_q[i], rom_word(0));

        // one-cycle reset in the middle of a run
        do_start(16'h0400);
        wait_issues(5);
        tick();
        rst_n = 1'b0;
        #1;
        chk("e_rst_busy", 32'(busy), 32'd0);
        chk("e_rst_rom_en", 32'(rom_en), 32'd0);
        chk("e_rst_addr", 32'(rom_addr), 32'd0);
        chk("e_rst_valid", 32'(smp_if.valid), 32'd0);
        chk("e_rst_data", smp_if.data, 32'd0);
        chk("e_rst_wrap", 32'(wrap), 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("e_post_valid0", 32'(smp_if.valid), 32'd0);
        tick();
        @(negedge clk);
        chk("e_post_valid1", 32'(smp_if.valid), 32'd0);
        chk("e_post_busy", 32'(busy), 32'd0);
        do_start(16'h0400);
        @(negedge clk);
        chk("e_restart_addr", 32'(rom_addr), 32'd0);
        chk("e_restart_rom_en", 32'(rom_en), 32'd1);
        wait_issues(6);
        stop_and_drain("e");
        for (int i = 0; i < addr_q.size(); i++) chk("e_addr", 32'(addr_q[i]), 32'(i % 64));
        for (int i = 0; i < smp_q.size(); i++) chk("e_sample", smp_q[i], rom_word(i % 64));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
